// File: rtl/winbuf_pkg.sv
// Shared types and helpers for the sliding window buffer.
package winbuf_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } state_t;

  localparam int PIX_W_DEF = 8;
  localparam int WIN_DEF   = 3;

  // Row-major packing: element (0,0) lands in the MSBs of the flattened window.
  function automatic int elem_lsb(input int row, input int col, input int win, input int pix_w);
    return ((win * win - 1) - (row * win + col)) * pix_w;
  endfunction

endpackage

// File: rtl/winbuf_col_shift.sv
// WIN x WIN pixel register array with per-element writes and a whole-array left column shift.
module winbuf_col_shift
  import winbuf_pkg::*;
#(
  parameter int PIX_W = PIX_W_DEF,
  parameter int WIN   = WIN_DEF,
  parameter int RC_W  = $clog2(WIN)
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     clr,
  input  logic                     shift,
  input  logic                     wr_en,
  input  logic [RC_W-1:0]          wr_row,
  input  logic [RC_W-1:0]          wr_col,
  input  logic [PIX_W-1:0]         wr_data,
  output logic [WIN*WIN*PIX_W-1:0] win_out
);

  logic [PIX_W-1:0] arr [WIN][WIN];

  // Shift never touches the rightmost column, so a same-cycle write there cannot collide.
  always_ff @(posedge clk) begin
    if (!n_rst || clr) begin
      for (int r = 0; r < WIN; r++)
        for (int c = 0; c < WIN; c++)
          arr[r][c] <= '0;
    end else begin
      if (shift) begin
        for (int r = 0; r < WIN; r++)
          for (int c = 0; c < WIN - 1; c++)
            arr[r][c] <= arr[r][c+1];
      end
      if (wr_en)
        arr[wr_row][wr_col] <= wr_data;
    end
  end

  for (genvar gr = 0; gr < WIN; gr++) begin : g_row
    for (genvar gc = 0; gc < WIN; gc++) begin : g_col
      assign win_out[elem_lsb(gr, gc, WIN, PIX_W) +: PIX_W] = arr[gr][gc];
    end
  end

endmodule

// File: rtl/sliding_window_buf.sv
// Sliding WIN x WIN window buffer: full fills and one-column slides with valid/ready on both sides.
// Optional WINBUF_WIN_CNT_EN adds win_count, a saturating count of window handshakes since start.
module sliding_window_buf
  import winbuf_pkg::*;
#(
  parameter int PIX_W = PIX_W_DEF,
  parameter int WIN   = WIN_DEF
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     start,
  input  logic                     abort,
  input  logic [PIX_W-1:0]         pix_in,
  input  logic                     pix_valid,
  output logic                     pix_ready,
  input  logic                     load_full,
  output logic [WIN*WIN*PIX_W-1:0] win_out,
  output logic                     win_valid,
  input  logic                     win_ready
`ifdef WINBUF_WIN_CNT_EN
  ,
  output logic [15:0]              win_count
`endif
);

  localparam int CNT_W = $clog2(WIN * WIN);
  localparam int RC_W  = $clog2(WIN);
  localparam logic [CNT_W-1:0] LAST_FILL  = CNT_W'(WIN * WIN - 1);
  localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(WIN - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             last_pix;
  logic             arr_shift;
  logic             arr_wr;
  logic [RC_W-1:0]  wr_row;
  logic [RC_W-1:0]  wr_col;

  assign pix_ready = (state == FILL) || (state == SHIFT);
  assign win_valid = (state == HOLD);
  assign accept    = pix_valid && pix_ready;
  assign last_pix  = (state == FILL) ? (cnt == LAST_FILL) : (cnt == LAST_SHIFT);

  // The column shift is tied to the first accepted slide pixel, so input gaps never cause extra shifts.
  assign arr_shift = accept && !abort && (state == SHIFT) && (cnt == '0);
  assign arr_wr    = accept && !abort;

  always_comb begin
    wr_row = RC_W'(cnt % WIN);
    wr_col = RC_W'(cnt / WIN);
    if (state == SHIFT) begin
      wr_row = RC_W'(cnt);
      wr_col = RC_W'(WIN - 1);
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst || abort) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= FILL;
            cnt   <= '0;
          end
        end
        FILL, SHIFT: begin
          if (accept) begin
            if (last_pix) state <= HOLD;
            else          cnt   <= cnt + 1'b1;
          end
        end
        HOLD: begin
          if (win_ready) begin
            state <= load_full ? FILL : SHIFT;
            cnt   <= '0;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

`ifdef WINBUF_WIN_CNT_EN
  always_ff @(posedge clk) begin
    if (!n_rst || abort)
      win_count <= '0;
    else if (state == IDLE && start)
      win_count <= '0;
    else if (state == HOLD && win_ready && win_count != 16'hFFFF)
      win_count <= win_count + 16'd1;
  end
`endif

  winbuf_col_shift #(
    .PIX_W (PIX_W),
    .WIN   (WIN),
    .RC_W  (RC_W)
  ) u_array (
    .clk     (clk),
    .n_rst   (n_rst),
    .clr     (abort),
    .shift   (arr_shift),
    .wr_en   (arr_wr),
    .wr_row  (wr_row),
    .wr_col  (wr_col),
    .wr_data (pix_in),
    .win_out (win_out)
  );

endmodule

// File: tb/tb_sliding_window_buf.sv
// Self-checking bench for sliding_window_buf; reference model keeps the stream of loaded columns.
module tb_sliding_window_buf;

  localparam int PIX_W = 8;
  localparam int WIN   = 3;
  localparam int WW    = WIN * WIN * PIX_W;
  localparam int CW    = WIN * PIX_W;

  logic             clk;
  logic             n_rst;
  logic             start;
  logic             abort;
  logic [PIX_W-1:0] pix_in;
  logic             pix_valid;
  logic             pix_ready;
  logic             load_full;
  logic [WW-1:0]    win_out;
  logic             win_valid;
  logic             win_ready;
`ifdef WINBUF_WIN_CNT_EN
  logic [15:0]      win_count;
`endif

  int checks = 0;
  int errors = 0;
  int model_count = 0;

  logic [CW-1:0]    cols [$];
  logic [PIX_W-1:0] stim [$];

  sliding_window_buf #(.PIX_W(PIX_W), .WIN(WIN)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .start     (start),
    .abort     (abort),
    .pix_in    (pix_in),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .load_full (load_full),
    .win_out   (win_out),
    .win_valid (win_valid),
    .win_ready (win_ready)
`ifdef WINBUF_WIN_CNT_EN
    ,
    .win_count (win_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // The window is always the last WIN columns of the column stream, row 0 first.
  function automatic logic [WW-1:0] model_window();
    logic [WW-1:0] w;
    int base;
    w = '0;
    if (cols.size() < WIN) return w;
    base = cols.size() - WIN;
    for (int r = 0; r < WIN; r++) begin
      for (int c = 0; c < WIN; c++) begin
        logic [CW-1:0] col;
        col = cols[base + c];
        w = {w[WW-PIX_W-1:0], col[(WIN-1-r)*PIX_W +: PIX_W]};
      end
    end
    return w;
  endfunction

  task automatic model_load(input bit full);
    int n;
    n = full ? WIN * WIN : WIN;
    for (int k = 0; k < n / WIN; k++) begin
      logic [CW-1:0] col;
      col = '0;
      for (int j = 0; j < WIN; j++)
        col = {col[CW-PIX_W-1:0], stim[k*WIN + j]};
      cols.push_back(col);
    end
    while (cols.size() > WIN) void'(cols.pop_front());
    stim.delete();
  endtask

  task automatic model_zero();
    cols.delete();
    for (int i = 0; i < WIN; i++) cols.push_back('0);
  endtask

  task automatic drive_pixel(input logic [PIX_W-1:0] p, input bit gaps);
    bit done;
    if (gaps) begin
      pix_valid = 1'b0;
      repeat ($urandom_range(0, 2)) tick();
    end
    pix_valid = 1'b1;
    pix_in    = p;
    done      = 1'b0;
    for (int t = 0; t < 50 && !done; t++) begin
      if (pix_ready) done = 1'b1;
      tick();
    end
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL pixel_accept_timeout: pix_ready stayed %b, required 1", pix_ready);
    end
  endtask

  task automatic drive_stim(input bit gaps);
    foreach (stim[i]) drive_pixel(stim[i], gaps);
    pix_valid = 1'b0;
  endtask

  task automatic handshake(input bit full);
    int t;
    t = 0;
    while (!win_valid && t < 50) begin
      tick();
      t++;
    end
    if (!win_valid) begin
      checks++;
      errors++;
      $display("[TB] FAIL handshake_timeout: win_valid=%b, required 1", win_valid);
    end
    win_ready = 1'b1;
    load_full = full;
    tick();
    win_ready = 1'b0;
    model_count++;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    model_count = 0;
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    repeat (2) tick();
    n_rst = 1'b1;
    pix_valid = 1'b1;
    pix_in = 8'h55;
    tick();
    checks++;
    if (pix_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_pix_ready: got %b, expected 0", pix_ready);
    end
    checks++;
    if (win_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_win_valid: got %b, expected 0", win_valid);
    end
    checks++;
    if (win_out !== '0) begin
      errors++;
      $display("[TB] FAIL reset_win_out: got %h, expected 0", win_out);
    end
    pix_valid = 1'b0;
    model_zero();
  endtask

  task automatic test_fill();
    do_start();
    pix_valid = 1'b1;
    for (int i = 1; i <= WIN * WIN; i++) begin
      stim.push_back(PIX_W'(i));
      pix_in = PIX_W'(i);
      tick();
      if (i == WIN * WIN - 1) begin
        checks++;
        if (win_valid !== 1'b0) begin
          errors++;
          $display("[TB] FAIL fill_early_valid: got %b, expected 0", win_valid);
        end
      end
    end
    pix_valid = 1'b0;
    model_load(1'b1);
    checks++;
    if (win_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL fill_win_valid: got %b, expected 1", win_valid);
    end
    checks++;
    if (win_out !== 72'h010407_020508_030609 || win_out !== model_window()) begin
      errors++;
      $display("[TB] FAIL fill_window: got %h, expected %h", win_out, model_window());
    end
  endtask

  task automatic test_slide();
    handshake(1'b0);
    checks++;
    if (win_valid !== 1'b0 || pix_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL slide_enter: got valid=%b ready=%b, expected valid=0 ready=1", win_valid, pix_ready);
    end
    stim = '{8'h0A, 8'h0B, 8'h0C};
    drive_stim(1'b0);
    model_load(1'b0);
    checks++;
    if (win_out !== 72'h04070A_05080B_06090C || win_out !== model_window()) begin
      errors++;
      $display("[TB] FAIL slide_window: got %h, expected %h", win_out, model_window());
    end
  endtask

  task automatic test_back_pressure();
    logic [WW-1:0] held;
    held = win_out;
    win_ready = 1'b0;
    pix_valid = 1'b1;
    pix_in = 8'hEE;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (pix_ready !== 1'b0 || win_valid !== 1'b1 || win_out !== held) begin
        errors++;
        $display("[TB] FAIL backpressure_hold[%0d]: got ready=%b valid=%b win=%h, expected ready=0 valid=1 win=%h",
                 i, pix_ready, win_valid, win_out, held);
      end
    end
    handshake(1'b0);
    stim = '{8'hEE, 8'($urandom), 8'($urandom)};
    drive_stim(1'b0);
    model_load(1'b0);
    checks++;
    if (win_out !== model_window()) begin
      errors++;
      $display("[TB] FAIL backpressure_window: got %h, expected %h", win_out, model_window());
    end
  endtask

  task automatic test_gapped();
    logic [WW-1:0] after_first;
    handshake(1'b1);
    for (int i = 1; i <= WIN * WIN; i++) stim.push_back(PIX_W'(i));
    drive_stim(1'b1);
    model_load(1'b1);
    handshake(1'b0);
    pix_valid = 1'b1; pix_in = 8'h0A; tick();
    after_first = win_out;
    pix_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (win_out !== after_first) begin
        errors++;
        $display("[TB] FAIL gap_no_shift[%0d]: got %h, expected %h", i, win_out, after_first);
      end
    end
    pix_valid = 1'b1; pix_in = 8'h0B; tick();
    pix_valid = 1'b0; tick();
    pix_valid = 1'b1; pix_in = 8'h0C; tick();
    pix_valid = 1'b0;
    stim = '{8'h0A, 8'h0B, 8'h0C};
    model_load(1'b0);
    checks++;
    if (win_valid !== 1'b1 || win_out !== 72'h04070A_05080B_06090C || win_out !== model_window()) begin
      errors++;
      $display("[TB] FAIL gapped_window: got valid=%b win=%h, expected valid=1 win=%h", win_valid, win_out, model_window());
    end
  endtask

  task automatic test_abort();
    handshake(1'b1);
    for (int i = 0; i < 4; i++) drive_pixel(8'($urandom), 1'b0);
    pix_valid = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    model_zero();
    model_count = 0;
    checks++;
    if (pix_ready !== 1'b0 || win_valid !== 1'b0 || win_out !== '0) begin
      errors++;
      $display("[TB] FAIL abort_clear: got ready=%b valid=%b win=%h, expected all 0", pix_ready, win_valid, win_out);
    end
    do_start();
    for (int i = 0; i < WIN * WIN; i++) stim.push_back(8'($urandom));
    drive_stim(1'b1);
    model_load(1'b1);
    checks++;
    if (win_valid !== 1'b1 || win_out !== model_window()) begin
      errors++;
      $display("[TB] FAIL abort_refill: got valid=%b win=%h, expected valid=1 win=%h", win_valid, win_out, model_window());
    end
  endtask

  task automatic test_reset_mid();
    logic [WW-1:0] held;
    handshake(1'b0);
    for (int i = 0; i < WIN; i++) stim.push_back(8'($urandom));
    drive_stim(1'b0);
    model_load(1'b0);
    handshake(1'b0);
    drive_pixel(8'h77, 1'b0);
    pix_valid = 1'b0;
`ifdef WINBUF_WIN_CNT_EN
    checks++;
    if (win_count !== 16'(model_count)) begin
      errors++;
      $display("[TB] FAIL win_count_two: got %0d, expected %0d", win_count, model_count);
    end
`endif
    held = win_out;
    n_rst = 1'b0;
    #3;
    n_rst = 1'b1;
    tick();
    checks++;
    if (pix_ready !== 1'b1 || win_out !== held) begin
      errors++;
      $display("[TB] FAIL reset_glitch_ignored: got ready=%b win=%h, expected ready=1 win=%h", pix_ready, win_out, held);
    end
    n_rst = 1'b0;
    tick();
    model_zero();
    model_count = 0;
    checks++;
    if (pix_ready !== 1'b0 || win_valid !== 1'b0 || win_out !== '0) begin
      errors++;
      $display("[TB] FAIL reset_mid_shift: got ready=%b valid=%b win=%h, expected all 0", pix_ready, win_valid, win_out);
    end
`ifdef WINBUF_WIN_CNT_EN
    checks++;
    if (win_count !== 16'd0) begin
      errors++;
      $display("[TB] FAIL win_count_reset: got %0d, expected 0", win_count);
    end
`endif
    n_rst = 1'b1;
    tick();
  endtask

  task automatic test_random();
    bit full;
    do_start();
    for (int i = 0; i < WIN * WIN; i++) stim.push_back(8'($urandom));
    drive_stim(1'b1);
    model_load(1'b1);
    for (int w = 0; w < 12; w++) begin
      repeat ($urandom_range(0, 2)) tick();
      full = 1'($urandom_range(0, 1));
      handshake(full);
      for (int i = 0; i < (full ? WIN * WIN : WIN); i++) stim.push_back(8'($urandom));
      drive_stim(1'b1);
      model_load(full);
      checks++;
      if (win_valid !== 1'b1 || win_out !== model_window()) begin
        errors++;
        $display("[TB] FAIL random_window[%0d]: got valid=%b win=%h, expected valid=1 win=%h",
                 w, win_valid, win_out, model_window());
      end
    end
`ifdef WINBUF_WIN_CNT_EN
    checks++;
    if (win_count !== 16'(model_count)) begin
      errors++;
      $display("[TB] FAIL win_count_random: got %0d, expected %0d", win_count, model_count);
    end
`endif
  endtask

  initial begin
    n_rst     = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    pix_in    = '0;
    pix_valid = 1'b0;
    load_full = 1'b0;
    win_ready = 1'b0;
    test_reset();
    test_fill();
    test_slide();
    test_back_pressure();
    test_gapped();
    test_abort();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
